// File: rtl/telemetry_tx_if.sv
// Bundle of the telemetry transmitter's sensor inputs, control strobes and UART-side outputs.
// The transmitter uses the slave view; whoever supplies the readings and triggers uses the master view.
interface telemetry_tx_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 12
);
  logic [NUM_CH*DATA_W-1:0] data;
  logic                     en;
  logic                     trig;
  logic                     TX;
  logic                     busy;
  logic                     pkt_done;

  modport master (output data, en, trig, input TX, busy, pkt_done);
  modport slave  (input data, en, trig, output TX, busy, pkt_done);
endinterface

// File: rtl/telemetry_tx.sv
// Multi-channel telemetry transmitter: snapshots NUM_CH readings on a tick or trigger and sends
// them as an AA 55 <payload> <~sum> packet over an 8N1 UART.
module telemetry_tx #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 12,
  parameter int BAUD_DIV = 434,
  parameter int PERIOD   = 1048576
) (
  input logic           clk,
  input logic           rst,
  telemetry_tx_if.slave bus
);
  localparam int BPC   = (DATA_W + 7) / 8;
  localparam int PAY   = NUM_CH * BPC;
  localparam int TOTAL = PAY + 3;
  localparam int BC_W  = $clog2(BAUD_DIV);
  localparam int TM_W  = $clog2(PERIOD);
  localparam int BI_W  = $clog2(TOTAL);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [BC_W-1:0]  baudCnt_q;
  logic [2:0]       bitIdx_q;
  logic [BI_W-1:0]  byteIdx_q;
  logic [7:0]       shift_q;
  logic [7:0]       sum_q;
  logic [PAY*8-1:0] snap_q;
  logic [PAY*8-1:0] snap_d;
  logic [BPC*8-1:0] chanPad;
  logic [TM_W-1:0]  timer_q;
  logic [TM_W-1:0]  timer_d;
  logic             pending_q;
  logic             tx_q;
  logic             busy_q;
  logic             pktDone_q;
  logic             tick;
  logic             req;
  logic             baudEnd;
  logic [BI_W-1:0]  nextIdx;
  logic [7:0]       payByte;

  always_comb begin
    timer_d = '0;
    if (bus.en && (timer_q != TM_W'(PERIOD - 1))) timer_d = timer_q + TM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  assign tick    = bus.en && (timer_q == TM_W'(PERIOD - 1));
  assign req     = bus.trig | tick;
  assign baudEnd = (baudCnt_q == BC_W'(BAUD_DIV - 1));
  assign nextIdx = byteIdx_q + BI_W'(1);
  assign payByte = snap_q[PAY*8-1 -: 8];

  // Channel 0 lands in the top bytes so the snapshot can simply be shifted out MSB-first.
  always_comb begin
    snap_d  = '0;
    chanPad = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chanPad                               = '0;
      chanPad[DATA_W-1:0]                   = bus.data[k*DATA_W +: DATA_W];
      snap_d[(NUM_CH-1-k)*BPC*8 +: BPC*8]   = chanPad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      byteIdx_q <= '0;
      shift_q   <= '0;
      sum_q     <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      pktDone_q <= 1'b0;
    end else begin
      pktDone_q <= 1'b0;
      if (state_q != IDLE) begin
        baudCnt_q <= baudEnd ? '0 : baudCnt_q + BC_W'(1);
        if (req) pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req || pending_q) begin
            state_q   <= START;
            snap_q    <= snap_d;
            pending_q <= 1'b0;
            byteIdx_q <= '0;
            shift_q   <= 8'hAA;
            sum_q     <= '0;
            baudCnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (baudEnd) begin
            state_q  <= DATA;
            bitIdx_q <= '0;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end
        end
        DATA: begin
          if (baudEnd) begin
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              tx_q     <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end
        STOP: begin
          if (baudEnd) begin
            if (byteIdx_q == BI_W'(TOTAL - 1)) begin
              state_q   <= IDLE;
              tx_q      <= 1'b1;
              busy_q    <= 1'b0;
              pktDone_q <= 1'b1;
            end else begin
              // Next byte starts immediately: second header, a payload byte, or the checksum.
              state_q   <= START;
              byteIdx_q <= nextIdx;
              tx_q      <= 1'b0;
              if (nextIdx == BI_W'(1)) begin
                shift_q <= 8'h55;
              end else if (nextIdx == BI_W'(TOTAL - 1)) begin
                shift_q <= ~sum_q;
              end else begin
                shift_q <= payByte;
                sum_q   <= sum_q + payByte;
                snap_q  <= snap_q << 8;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.TX       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.pkt_done = pktDone_q;
endmodule

// File: tb/tb_telemetry_tx.sv
// Directed bench for telemetry_tx: a 3x12-bit instance (BAUD_DIV=4) and a 2x8-bit periodic
// instance (BAUD_DIV=2, PERIOD=200), with a mid-bit UART sampler decoding the TX line.
module tb_telemetry_tx;
  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   busyA = 0;
  int   doneA = 0;
  int   doneB = 0;
  logic [7:0] rxBytes [16];
  logic [7:0] expA [9] = '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h07};
  logic [7:0] expB [5] = '{8'hAA, 8'h55, 8'h10, 8'h20, 8'hCF};

  telemetry_tx_if #(.NUM_CH(3), .DATA_W(12)) ifA ();
  telemetry_tx_if #(.NUM_CH(2), .DATA_W(8))  ifB ();

  telemetry_tx #(.NUM_CH(3), .DATA_W(12), .BAUD_DIV(4), .PERIOD(1048576)) dutA (
    .clk(clk), .rst(rstA), .bus(ifA)
  );
  telemetry_tx #(.NUM_CH(2), .DATA_W(8), .BAUD_DIV(2), .PERIOD(200)) dutB (
    .clk(clk), .rst(rstB), .bus(ifB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifA.busy === 1'b1)     busyA <= busyA + 1;
    if (ifA.pkt_done === 1'b1) doneA <= doneA + 1;
    if (ifB.pkt_done === 1'b1) doneB <= doneB + 1;
  end

  function automatic logic txOf(input int which);
    return (which == 0) ? ifA.TX : ifB.TX;
  endfunction

  // Waits (bounded) for a start bit, then samples every bit at mid-period; returns at the cycle
  // after the last stop bit. ok drops on timeout or a bad start/stop bit.
  task automatic capture(input int which, input int baud, input int nbytes, input int timeout,
                         output int startCyc, output bit ok);
    int         waited;
    logic [9:0] fr;
    waited   = 0;
    ok       = 1'b1;
    startCyc = -1;
    for (int b = 0; b < 16; b++) rxBytes[b] = 8'hxx;
    while (txOf(which) !== 1'b0 && waited < timeout) begin
      @(negedge clk);
      waited++;
    end
    if (txOf(which) !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    startCyc = cyc;
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 10; i++) begin
        repeat (baud / 2) @(negedge clk);
        fr[i] = txOf(which);
        repeat (baud - baud / 2) @(negedge clk);
      end
      rxBytes[b] = fr[8:1];
      if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lowCnt;
    rstA = 1'b1; rstB = 1'b1;
    ifA.trig = 1'b1; ifB.trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      testsRun++;
      if ({ifA.TX, ifA.busy, ifA.pkt_done} !== 3'b100) begin
        testsFailed++;
        $display("[TB] FAIL reset_A%0d: TX/busy/done got %b expected 100", i,
                 {ifA.TX, ifA.busy, ifA.pkt_done});
      end
      testsRun++;
      if ({ifB.TX, ifB.busy, ifB.pkt_done} !== 3'b100) begin
        testsFailed++;
        $display("[TB] FAIL reset_B%0d: TX/busy/done got %b expected 100", i,
                 {ifB.TX, ifB.busy, ifB.pkt_done});
      end
    end
    rstA = 1'b0; rstB = 1'b0;
    ifA.trig = 1'b0; ifB.trig = 1'b0;
    lowCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifA.TX !== 1'b1 || ifA.busy !== 1'b0) lowCnt++;
    end
    testsRun++;
    if (lowCnt !== 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_packet: active cycles got %0d expected 0", lowCnt);
    end
  endtask

  task automatic test_frame();
    int sc, b0, d0, c0;
    bit ok;
    ifA.data = {12'hABC, 12'h123, 12'hFFF};
    @(negedge clk);
    b0 = busyA; d0 = doneA; c0 = cyc;
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    capture(0, 4, 9, 20, sc, ok);
    testsRun++;
    if (sc !== c0 + 1) begin
      testsFailed++;
      $display("[TB] FAIL frame_start: start cycle got %0d expected %0d", sc, c0 + 1);
    end
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL frame_framing: ok got %0d expected 1", ok);
    end
    for (int b = 0; b < 9; b++) begin
      testsRun++;
      if (rxBytes[b] !== expA[b]) begin
        testsFailed++;
        $display("[TB] FAIL frame_byte%0d: got %h expected %h", b, rxBytes[b], expA[b]);
      end
    end
    testsRun++;
    if ({ifA.busy, ifA.pkt_done} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL frame_done_cycle: busy/done got %b expected 01", {ifA.busy, ifA.pkt_done});
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (busyA - b0 !== 360) begin
      testsFailed++;
      $display("[TB] FAIL frame_busy_len: got %0d expected 360", busyA - b0);
    end
    testsRun++;
    if (doneA - d0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL frame_done_count: got %0d expected 1", doneA - d0);
    end
  endtask

  task automatic test_snapshot();
    int sc, c0;
    bit ok;
    ifA.data = {12'hABC, 12'h123, 12'hFFF};
    @(negedge clk);
    c0 = cyc;
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    fork
      capture(0, 4, 9, 20, sc, ok);
      begin
        repeat (125) @(negedge clk);
        ifA.data = '0;
      end
    join
    testsRun++;
    if (sc !== c0 + 1 || ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL snap_frame: start %0d ok %0d expected start %0d ok 1", sc, ok, c0 + 1);
    end
    for (int b = 0; b < 9; b++) begin
      testsRun++;
      if (rxBytes[b] !== expA[b]) begin
        testsFailed++;
        $display("[TB] FAIL snap_byte%0d: got %h expected %h", b, rxBytes[b], expA[b]);
      end
    end
    ifA.data = {12'hABC, 12'h123, 12'hFFF};
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sc, sc2, p, b0, d0;
    bit ok, ok2;
    @(negedge clk);
    b0 = busyA; d0 = doneA;
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    fork
      capture(0, 4, 9, 20, sc, ok);
      begin
        for (int t = 0; t < 3; t++) begin
          repeat (60) @(negedge clk);
          ifA.trig = 1'b1;
          @(negedge clk);
          ifA.trig = 1'b0;
        end
      end
    join
    p = cyc;
    testsRun++;
    if (ifA.busy !== 1'b0 || ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL queue_first: busy %b ok %0d expected busy 0 ok 1", ifA.busy, ok);
    end
    capture(0, 4, 9, 5, sc2, ok2);
    testsRun++;
    if (sc2 !== p + 1) begin
      testsFailed++;
      $display("[TB] FAIL queue_gap: second start got %0d expected %0d", sc2, p + 1);
    end
    testsRun++;
    if (ok2 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL queue_framing: ok got %0d expected 1", ok2);
    end
    for (int b = 0; b < 9; b++) begin
      testsRun++;
      if (rxBytes[b] !== expA[b]) begin
        testsFailed++;
        $display("[TB] FAIL queue_byte%0d: got %h expected %h", b, rxBytes[b], expA[b]);
      end
    end
    repeat (200) @(negedge clk);
    testsRun++;
    if (doneA - d0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL queue_packets: got %0d expected 2", doneA - d0);
    end
    testsRun++;
    if (busyA - b0 !== 720) begin
      testsFailed++;
      $display("[TB] FAIL queue_busy: got %0d expected 720", busyA - b0);
    end
  endtask

  task automatic test_periodic();
    int sc, e, d0;
    bit ok;
    ifB.data = {8'h20, 8'h10};
    @(negedge clk);
    e = cyc; d0 = doneB;
    ifB.en = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      capture(1, 2, 5, 260, sc, ok);
      testsRun++;
      if (sc !== e + 200 * n) begin
        testsFailed++;
        $display("[TB] FAIL periodic_start%0d: got %0d expected %0d", n, sc, e + 200 * n);
      end
      testsRun++;
      if (ok !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL periodic_framing%0d: ok got %0d expected 1", n, ok);
      end
      for (int b = 0; b < 5; b++) begin
        testsRun++;
        if (rxBytes[b] !== expB[b]) begin
          testsFailed++;
          $display("[TB] FAIL periodic%0d_byte%0d: got %h expected %h", n, b, rxBytes[b], expB[b]);
        end
      end
    end
    ifB.en = 1'b0;
    repeat (450) @(negedge clk);
    testsRun++;
    if (doneB - d0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL periodic_stop: packets got %0d expected 2", doneB - d0);
    end
  endtask

  task automatic test_reset_mid();
    int sc, d0, b0;
    bit ok;
    ifA.data = {12'hABC, 12'h123, 12'hFFF};
    @(negedge clk);
    d0 = doneA;
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    repeat (49) @(negedge clk);
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    repeat (119) @(negedge clk);
    rstA = 1'b1;
    @(negedge clk);
    rstA = 1'b0;
    testsRun++;
    if ({ifA.TX, ifA.busy, ifA.pkt_done} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL midreset_abort: TX/busy/done got %b expected 100",
               {ifA.TX, ifA.busy, ifA.pkt_done});
    end
    b0 = busyA;
    repeat (500) @(negedge clk);
    testsRun++;
    if (doneA !== d0 || busyA !== b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_quiet: done delta %0d busy delta %0d expected 0 0",
               doneA - d0, busyA - b0);
    end
    ifA.trig = 1'b1;
    @(negedge clk);
    ifA.trig = 1'b0;
    capture(0, 4, 9, 20, sc, ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_framing: ok got %0d expected 1", ok);
    end
    for (int b = 0; b < 9; b++) begin
      testsRun++;
      if (rxBytes[b] !== expA[b]) begin
        testsFailed++;
        $display("[TB] FAIL midreset_byte%0d: got %h expected %h", b, rxBytes[b], expA[b]);
      end
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (doneA - d0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_done: got %0d expected 1", doneA - d0);
    end
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    ifA.data = '0; ifA.en = 1'b0; ifA.trig = 1'b0;
    ifB.data = '0; ifB.en = 1'b0; ifB.trig = 1'b0;
    test_reset();
    test_frame();
    test_snapshot();
    test_back_to_back();
    test_periodic();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
